// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl : debounced MODE/INC time-setting controller for the clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module time_set_ctrl #(
  parameter int DEB_LEN       = 4,
  parameter int TIMEOUT_TICKS = 255,
  parameter int RPT_DELAY     = 32,
  parameter int RPT_RATE      = 8
) (
  input  logic       clk,
  input  logic       RESETn,
  input  logic       sample_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       load,
  output logic [5:0] data_hour,
  output logic [5:0] data_min,
  output logic [5:0] data_sec,
  output logic       edit_mode,
  output logic [5:0] disp_hour,
  output logic [5:0] disp_min,
  output logic [3:0] blink_sel
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam int              HW        = $clog2(RPT_DELAY + 1);
  localparam int              RW        = $clog2(RPT_RATE + 1);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(RPT_DELAY);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RPT_DELAY - 1);
  localparam logic [RW-1:0]   RATE_LAST = RW'(RPT_RATE - 1);
  localparam logic [7:0]      TO_MAX    = 8'(TIMEOUT_TICKS);

  logic [1:0] raw_btn;
  logic [1:0] level;
  logic [1:0] press;

  assign raw_btn = {btn_inc, btn_mode};

  // Bit 0 = MODE, bit 1 = INC
  genvar i;
  for (i = 0; i < 2; i++) begin : g_deb
    logic               s1, s2, lvl_r, lvl_q;
    logic [DEB_LEN-1:0] shift;
    logic [DEB_LEN-1:0] shift_nxt;

    assign shift_nxt = {shift[DEB_LEN-2:0], s2};

    always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl_r <= 1'b0;
        lvl_q <= 1'b0;
        shift <= '0;
      end else begin
        s1    <= raw_btn[i];
        s2    <= s1;
        lvl_q <= lvl_r;
        if (sample_tick) begin
          shift <= shift_nxt;
          if (&shift_nxt)
            lvl_r <= 1'b1;
          else if (~|shift_nxt)
            lvl_r <= 1'b0;
        end
      end
    end

    assign level[i] = lvl_r;
    assign press[i] = lvl_r & ~lvl_q;
  end

  logic unused_mode_level;
  assign unused_mode_level = level[0];

  state_t        state, state_nxt;
  logic [5:0]    edit_hour, edit_min;
  logic [7:0]    to_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rate_cnt;
  logic          rpt;
  logic          mode_press, inc_press, inc_level;
  logic          editing, timed_out, inc_evt;

  assign mode_press = press[0];
  assign inc_press  = press[1];
  assign inc_level  = level[1];
  assign editing    = (state == SET_HOUR) || (state == SET_MIN);
  assign timed_out  = (to_cnt == TO_MAX);
  // MODE wins over a coincident INC
  assign inc_evt    = (inc_press | rpt) & ~mode_press;
  assign edit_mode  = editing;
  assign data_sec   = 6'd0;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (mode_press) state_nxt = SET_HOUR;
      SET_HOUR: if (mode_press) state_nxt = SET_MIN;
                else if (timed_out) state_nxt = IDLE;
      SET_MIN:  if (mode_press) state_nxt = COMMIT;
                else if (timed_out) state_nxt = IDLE;
      COMMIT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      to_cnt <= 8'd0;
    end else if (!editing || mode_press || inc_press) begin
      to_cnt <= 8'd0;
    end else if (sample_tick && !timed_out) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // Hold counter runs to RPT_DELAY, then the rate counter paces repeats
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      hold_cnt <= '0;
      rate_cnt <= '0;
      rpt      <= 1'b0;
    end else begin
      rpt <= 1'b0;
      if (!inc_level || !editing || (state_nxt != state)) begin
        hold_cnt <= '0;
        rate_cnt <= '0;
      end else if (sample_tick) begin
        if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) rpt <= 1'b1;
        end else if (rate_cnt == RATE_LAST) begin
          rate_cnt <= '0;
          rpt      <= 1'b1;
        end else begin
          rate_cnt <= rate_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      edit_hour <= 6'd0;
      edit_min  <= 6'd0;
    end else begin
      case (state)
        IDLE: if (mode_press) begin
          edit_hour <= cur_hour;
          edit_min  <= cur_min;
        end
        SET_HOUR: if (inc_evt)
          edit_hour <= (edit_hour == 6'd23) ? 6'd0 : edit_hour + 6'd1;
        SET_MIN: if (inc_evt)
          edit_min <= (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      load      <= 1'b0;
      data_hour <= 6'd0;
      data_min  <= 6'd0;
      disp_hour <= 6'd0;
      disp_min  <= 6'd0;
      blink_sel <= 4'b0000;
    end else begin
      load <= (state_nxt == COMMIT);
      if (state_nxt == COMMIT) begin
        data_hour <= edit_hour;
        data_min  <= edit_min;
      end
      disp_hour <= editing ? edit_hour : cur_hour;
      disp_min  <= editing ? edit_min  : cur_min;
      case (state)
        SET_HOUR: blink_sel <= 4'b1100;
        SET_MIN:  blink_sel <= 4'b0011;
        default:  blink_sel <= 4'b0000;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl : directed self-checking bench for time_set_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       RESETn;
  logic       sample_tick;
  logic       btn_mode, btn_inc;
  logic [5:0] cur_hour, cur_min;
  logic       load;
  logic [5:0] data_hour, data_min, data_sec;
  logic       edit_mode;
  logic [5:0] disp_hour, disp_min;
  logic [3:0] blink_sel;

  int total = 0;
  int bad   = 0;
  int load_cnt = 0;
  logic [5:0] last_dh = 6'd0, last_dm = 6'd0, last_ds = 6'd0;

  time_set_ctrl dut (
    .clk        (clk),
    .RESETn     (RESETn),
    .sample_tick(sample_tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .load       (load),
    .data_hour  (data_hour),
    .data_min   (data_min),
    .data_sec   (data_sec),
    .edit_mode  (edit_mode),
    .disp_hour  (disp_hour),
    .disp_min   (disp_min),
    .blink_sel  (blink_sel)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt = load_cnt + 1;
      last_dh  = data_hour;
      last_dm  = data_min;
      last_ds  = data_sec;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  endtask

  task automatic press_btn(input bit is_inc);
    if (is_inc) btn_inc = 1'b1; else btn_mode = 1'b1;
    tick(5);
    btn_inc  = 1'b0;
    btn_mode = 1'b0;
    tick(5);
  endtask

  task automatic pulse_reset();
    RESETn = 1'b0;
    @(negedge clk);
    RESETn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    RESETn      = 1'b0;
    sample_tick = 1'b0;
    btn_mode    = 1'b0;
    btn_inc     = 1'b0;
    cur_hour    = 6'd7;
    cur_min     = 6'd30;
    repeat (3) @(negedge clk);
    RESETn = 1'b1;
    tick(3);

    // reset asserted mid-run
    RESETn = 1'b0;
    @(negedge clk);
    check("rst_load",      32'(load),      32'd0);
    check("rst_data_hour", 32'(data_hour), 32'd0);
    check("rst_data_min",  32'(data_min),  32'd0);
    check("rst_data_sec",  32'(data_sec),  32'd0);
    check("rst_edit_mode", 32'(edit_mode), 32'd0);
    check("rst_blink",     32'(blink_sel), 32'd0);
    RESETn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_disp_hour", 32'(disp_hour), 32'd7);
    check("idle_disp_min",  32'(disp_min),  32'd30);
    check("idle_edit_mode", 32'(edit_mode), 32'd0);
    check("idle_no_load",   32'(load_cnt),  32'd0);

    // bounce rejection
    for (int k = 0; k < 20; k++) begin
      btn_mode = (k % 2 == 0);
      tick(1);
    end
    check("bounce_no_press", 32'(edit_mode), 32'd0);
    btn_mode = 1'b1;
    tick(4);
    repeat (3) @(negedge clk);
    check("bounce_edit_mode", 32'(edit_mode), 32'd1);
    check("bounce_blink",     32'(blink_sel), 32'b1100);
    check("bounce_disp_hour", 32'(disp_hour), 32'd7);
    btn_mode = 1'b0;
    tick(5);
    check("bounce_single_press", 32'(blink_sel), 32'b1100);

    // counter changes after entry do not affect the edit value
    cur_hour = 6'd12;
    repeat (2) @(negedge clk);
    check("no_resample_hour", 32'(disp_hour), 32'd7);
    press_btn(1'b0);
    check("setmin_blink",    32'(blink_sel), 32'b0011);
    check("setmin_disp_min", 32'(disp_min),  32'd30);
    pulse_reset();
    check("abort_edit_mode", 32'(edit_mode), 32'd0);
    check("abort_no_load",   32'(load_cnt),  32'd0);
    check("abort_disp_hour", 32'(disp_hour), 32'd12);

    // full set with wrap from 23:59
    cur_hour = 6'd23;
    cur_min  = 6'd59;
    press_btn(1'b0);
    check("wrap_entry_hour", 32'(disp_hour), 32'd23);
    press_btn(1'b1);
    check("wrap_hour", 32'(disp_hour), 32'd0);
    press_btn(1'b0);
    check("wrap_min_entry", 32'(disp_min), 32'd59);
    press_btn(1'b1);
    check("wrap_min", 32'(disp_min), 32'd0);
    press_btn(1'b0);
    check("wrap_load_cnt",  32'(load_cnt),  32'd1);
    check("wrap_data_hour", 32'(last_dh),   32'd0);
    check("wrap_data_min",  32'(last_dm),   32'd0);
    check("wrap_data_sec",  32'(last_ds),   32'd0);
    check("wrap_idle",      32'(edit_mode), 32'd0);
    check("wrap_blink",     32'(blink_sel), 32'd0);

    // auto-repeat: 10 + press + first repeat + 5 rate repeats = 17
    cur_hour = 6'd5;
    cur_min  = 6'd10;
    press_btn(1'b0);
    press_btn(1'b0);
    check("rpt_start_min", 32'(disp_min), 32'd10);
    btn_inc = 1'b1;
    tick(78);
    btn_inc = 1'b0;
    tick(6);
    check("rpt_min", 32'(disp_min), 32'd17);
    press_btn(1'b0);
    check("rpt_load_cnt",  32'(load_cnt), 32'd2);
    check("rpt_data_hour", 32'(last_dh),  32'd5);
    check("rpt_data_min",  32'(last_dm),  32'd17);
    tick(2);
    check("hold_data_hour", 32'(data_hour), 32'd5);
    check("hold_data_min",  32'(data_min),  32'd17);

    // simultaneous MODE and INC in SET_HOUR
    cur_hour = 6'd3;
    cur_min  = 6'd20;
    press_btn(1'b0);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    tick(5);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(5);
    check("simul_blink",     32'(blink_sel), 32'b0011);
    check("simul_disp_hour", 32'(disp_hour), 32'd3);
    check("simul_disp_min",  32'(disp_min),  32'd20);
    pulse_reset();
    check("simul_rst_idle",    32'(edit_mode), 32'd0);
    check("simul_rst_no_load", 32'(load_cnt),  32'd2);

    // timeout
    press_btn(1'b0);
    tick(240);
    check("to_still_editing", 32'(edit_mode), 32'd1);
    tick(20);
    check("to_idle",    32'(edit_mode), 32'd0);
    check("to_blink",   32'(blink_sel), 32'd0);
    check("to_no_load", 32'(load_cnt),  32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
